// File: rtl/cpu_regs_mp.sv
// cpu_regs_mp: multi-port integer register file with two write-back ports,
// same-cycle forwarding, a pending-write busy scoreboard and a post-reset
// clear sweep that zeroes the storage so the array itself needs no reset.
module cpu_regs_mp #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          we_i,
    input  logic [2*AW-1:0]     waddr_i,
    input  logic [2*XLEN-1:0]   wdata_i,
    input  logic                set_i,
    input  logic [AW-1:0]       set_addr_i,
    input  logic                flush_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]      rbusy_o,
    output logic                ready_o
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t           state, state_next;
    logic [AW-1:0]    cnt;
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    logic [AW-1:0]    wa0, wa1;
    logic [XLEN-1:0]  wd0, wd1;
    logic [1:0]       wen;
    logic             run;
    logic             set_ok;

    assign wa0 = waddr_i[0 +: AW];
    assign wa1 = waddr_i[AW +: AW];
    assign wd0 = wdata_i[0 +: XLEN];
    assign wd1 = wdata_i[XLEN +: XLEN];
    assign run = (state == RUN);

    // Writes and issues are only accepted in RUN; x0 is never written or claimed.
    assign wen[0] = run && we_i[0] && (wa0 != '0);
    assign wen[1] = run && we_i[1] && (wa1 != '0);
    assign set_ok = run && set_i && (set_addr_i != '0);

    // State register: INIT after reset, RUN once the sweep is finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_next;
    end

    // Next state: leave INIT after the cycle that clears the last register.
    always_comb begin
        state_next = state;
        if (state == INIT && cnt == LAST) state_next = RUN;
    end

    // Outputs of the state machine.
    always_comb begin
        ready_o = (state == RUN);
    end

    // Sweep counter: walks every register index once after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (state == INIT)  cnt <= cnt + AW'(1);
    end

    // Storage: zeroed by the sweep, then updated by the write ports.
    // NOTE: the array has no reset branch on purpose; the sweep provides the
    // known-zero contents, which keeps this mappable onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            regs[cnt] <= '0;
        end else begin
            if (wen[0]) regs[wa0] <= wd0;
            if (wen[1]) regs[wa1] <= wd1;
        end
    end

    // Scoreboard: retire clears, issue sets, flush clears everything.
    // NOTE: the later non-blocking assignment to the same bit wins, so port 1
    // beats port 0 above and an issue beats a retire here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (run) begin
            if (flush_i) begin
                busy <= '0;
            end else begin
                if (wen[0]) busy[wa0] <= 1'b0;
                if (wen[1]) busy[wa1] <= 1'b0;
                if (set_ok) busy[set_addr_i] <= 1'b1;
            end
        end
    end

    // Read ports: x0, then write port 1 forward, then port 0, then storage.
    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        if (run) begin
            for (int j = 0; j < NRD; j++) begin
                if (raddr_i[j*AW +: AW] == '0) begin
                    rdata_o[j*XLEN +: XLEN] = '0;
                end else if (wen[1] && wa1 == raddr_i[j*AW +: AW]) begin
                    rdata_o[j*XLEN +: XLEN] = wd1;
                end else if (wen[0] && wa0 == raddr_i[j*AW +: AW]) begin
                    rdata_o[j*XLEN +: XLEN] = wd0;
                end else begin
                    rdata_o[j*XLEN +: XLEN] = regs[raddr_i[j*AW +: AW]];
                    rbusy_o[j]              = busy[raddr_i[j*AW +: AW]];
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_regs_mp.sv
// tb_cpu_regs_mp: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the register file.
module tb_cpu_regs_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          we;
    logic [2*AW-1:0]     waddr;
    logic [2*XLEN-1:0]   wdata;
    logic                set;
    logic [AW-1:0]       set_addr;
    logic                flush;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                ready;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Behavioural model
    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];
    int              m_sweep_left;

    cpu_regs_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (we),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .set_i      (set),
        .set_addr_i (set_addr),
        .flush_i    (flush),
        .raddr_i    (raddr),
        .rdata_o    (rdata),
        .rbusy_o    (rbusy),
        .ready_o    (ready)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_sweep_left = NREGS;
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic bit m_ready();
        return m_sweep_left == 0;
    endfunction

    // Effect of one rising edge given the currently driven inputs.
    function automatic void model_edge();
        if (!m_ready()) begin
            m_sweep_left--;
            return;
        end
        for (int k = 0; k < 2; k++)
            if (we[k] && waddr[k*AW +: AW] != 0) begin
                m_regs[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
                m_busy[waddr[k*AW +: AW]] = 1'b0;
            end
        if (set && set_addr != 0) m_busy[set_addr] = 1'b1;
        if (flush)
            for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    endfunction

    // Expected combinational read for one address under current inputs.
    function automatic void exp_rd(input logic [AW-1:0] a,
                                   output logic [XLEN-1:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (!m_ready() || a == 0) return;
        if (we[1] && waddr[AW +: AW] == a)      d = wdata[XLEN +: XLEN];
        else if (we[0] && waddr[0 +: AW] == a)  d = wdata[0 +: XLEN];
        else begin
            d = m_regs[a];
            b = m_busy[a];
        end
    endfunction

    task automatic idle_inputs();
        we = '0; waddr = '0; wdata = '0;
        set = 1'b0; set_addr = '0; flush = 1'b0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic random_inputs();
        we       = 2'($urandom_range(0, 3));
        waddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        wdata    = {$urandom, $urandom};
        set      = 1'($urandom_range(0, 1));
        set_addr = 5'($urandom_range(0, 7));
        flush    = ($urandom_range(0, 15) == 0);
        raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    endtask

    task automatic test_reset();
        logic [XLEN-1:0] ed;
        logic            eb;
        rst_n = 1'b0;
        idle_inputs();
        raddr = '0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < NREGS; c++) begin
            random_inputs();
            #1;
            vectors++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready_low cyc=%0d got=%b exp=0", c, ready);
            end
            for (int j = 0; j < NRD; j++) begin
                exp_rd(raddr[j*AW +: AW], ed, eb);
                vectors++;
                if (rdata[j*XLEN +: XLEN] !== 32'h0 || rbusy[j] !== 1'b0 ||
                    ed !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_read cyc=%0d port=%0d got=%h/%b exp=0/0",
                             c, j, rdata[j*XLEN +: XLEN], rbusy[j]);
                end
            end
            tick();
        end
        idle_inputs();
        #1;
        vectors++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_high got=%b exp=1", ready);
        end
        // registers touched by garbage during the sweep must still be zero
        for (int a = 1; a < 8; a++) begin
            raddr = {5'(a), 5'(a)};
            #1;
            vectors++;
            if (rdata[0 +: XLEN] !== 32'h0 || rbusy[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_clean x%0d got=%h/%b exp=0/0", a,
                         rdata[0 +: XLEN], rbusy[0]);
            end
        end
    endtask

    task automatic test_write_forward();
        idle_inputs();
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
        raddr = {5'd0, 5'd5};
        #1;
        vectors++;
        if (rdata[0 +: XLEN] !== 32'hDEADBEEF || rbusy[0] !== 1'b0) begin
            errors++;
            $display("FAIL fwd_x5 got=%h/%b exp=deadbeef/0", rdata[0 +: XLEN], rbusy[0]);
        end
        vectors++;
        if (rdata[XLEN +: XLEN] !== 32'h0) begin
            errors++;
            $display("FAIL fwd_x0_port1 got=%h exp=0", rdata[XLEN +: XLEN]);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (rdata[0 +: XLEN] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL stored_x5 got=%h exp=deadbeef", rdata[0 +: XLEN]);
        end
        we = 2'b01; waddr = '0; wdata = {32'h0, 32'hFFFFFFFF}; raddr = '0;
        #1;
        vectors++;
        if (rdata[0 +: XLEN] !== 32'h0) begin
            errors++;
            $display("FAIL x0_fwd got=%h exp=0", rdata[0 +: XLEN]);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (rdata[0 +: XLEN] !== 32'h0) begin
            errors++;
            $display("FAIL x0_stored got=%h exp=0", rdata[0 +: XLEN]);
        end
    endtask

    task automatic test_dual_write();
        idle_inputs();
        we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11};
        raddr = {5'd7, 5'd7};
        #1;
        vectors++;
        if (rdata[0 +: XLEN] !== 32'h22 || rdata[XLEN +: XLEN] !== 32'h22) begin
            errors++;
            $display("FAIL dual_fwd got=%h,%h exp=22,22", rdata[0 +: XLEN], rdata[XLEN +: XLEN]);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (rdata[0 +: XLEN] !== 32'h22) begin
            errors++;
            $display("FAIL dual_stored got=%h exp=22", rdata[0 +: XLEN]);
        end
    endtask

    task automatic test_busy_set_clear();
        idle_inputs();
        set = 1'b1; set_addr = 5'd9; raddr = {5'd0, 5'd9};
        #1;
        vectors++;
        if (rbusy[0] !== 1'b0) begin
            errors++;
            $display("FAIL busy_same_cycle got=%b exp=0", rbusy[0]);
        end
        tick();
        set = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (rbusy[0] !== 1'b1) begin
                errors++;
                $display("FAIL busy_pending cyc=%0d got=%b exp=1", c, rbusy[0]);
            end
            tick();
        end
        we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h5};
        #1;
        vectors++;
        if (rbusy[0] !== 1'b0 || rdata[0 +: XLEN] !== 32'h5) begin
            errors++;
            $display("FAIL busy_wb_cycle got=%h/%b exp=5/0", rdata[0 +: XLEN], rbusy[0]);
        end
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (rbusy[0] !== 1'b0 || rdata[0 +: XLEN] !== 32'h5) begin
            errors++;
            $display("FAIL busy_after_wb got=%h/%b exp=5/0", rdata[0 +: XLEN], rbusy[0]);
        end
    endtask

    task automatic test_set_write_flush();
        idle_inputs();
        set = 1'b1; set_addr = 5'd9;
        we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h77};
        tick();
        idle_inputs();
        raddr = {5'd10, 5'd9};
        #1;
        vectors++;
        if (rbusy[0] !== 1'b1 || rdata[0 +: XLEN] !== 32'h77) begin
            errors++;
            $display("FAIL set_wins got=%h/%b exp=77/1", rdata[0 +: XLEN], rbusy[0]);
        end
        flush = 1'b1; set = 1'b1; set_addr = 5'd10;
        we = 2'b01; waddr = {5'd0, 5'd12}; wdata = {32'h0, 32'hABC};
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (rbusy !== 2'b00) begin
            errors++;
            $display("FAIL flush_clear got=%b exp=00", rbusy);
        end
        raddr = {5'd0, 5'd12};
        #1;
        vectors++;
        if (rdata[0 +: XLEN] !== 32'hABC) begin
            errors++;
            $display("FAIL flush_write_lands got=%h exp=abc", rdata[0 +: XLEN]);
        end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] ed;
        logic            eb;
        for (int c = 0; c < 400; c++) begin
            random_inputs();
            #1;
            for (int j = 0; j < NRD; j++) begin
                exp_rd(raddr[j*AW +: AW], ed, eb);
                vectors++;
                if (rdata[j*XLEN +: XLEN] !== ed || rbusy[j] !== eb) begin
                    errors++;
                    $display("FAIL random cyc=%0d port=%0d addr=%0d got=%h/%b exp=%h/%b",
                             c, j, raddr[j*AW +: AW], rdata[j*XLEN +: XLEN], rbusy[j], ed, eb);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
        set = 1'b1; set_addr = 5'd3;
        tick();
        idle_inputs();
        set = 1'b1; set_addr = 5'd4;
        tick();
        idle_inputs();
        raddr = {5'd4, 5'd3};
        #1;
        vectors++;
        if (rbusy !== 2'b11 || ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy got=%b rdy=%b exp=11 rdy=1", rbusy, ready);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL async_ready_drop got=%b exp=0", ready);
        end
        tick();
        rst_n = 1'b1;
        repeat (NREGS) tick();
        raddr = {5'd4, 5'd3};
        #1;
        vectors++;
        if (ready !== 1'b1 || rbusy !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_busy rdy=%b busy=%b exp rdy=1 busy=00", ready, rbusy);
        end
        raddr = {5'd7, 5'd5};
        #1;
        vectors++;
        if (rdata !== 64'h0) begin
            errors++;
            $display("FAIL post_reset_regs got=%h exp=0", rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_forward();
        test_dual_write();
        test_busy_set_clear();
        test_set_write_flush();
        test_random();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cpu_regs_mp.md
# cpu_regs_mp

Parametrised multi-port integer register file for the priRV32 core: configurable data width, register count and read-port count, two write-back ports with same-cycle forwarding. Adds a pending-write scoreboard (busy bit per register, set at issue, cleared at write-back) so ID can detect RAW hazards. Adds a post-reset clear sweep, so the storage array needs no reset. Sits between ID (read/issue) and EX/WB (write-back).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, ≥ 4; AW = log2(NREGS)
- NRD, 2, number of read ports (1..4)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- we_i  in  2  write enables; bit k belongs to write port k
- waddr_i  in  2*AW  write addresses; port k at [k*AW +: AW]
- wdata_i  in  2*XLEN  write data; port k at [k*XLEN +: XLEN]
- set_i  in  1  issue: mark set_addr_i busy (pending writer)
- set_addr_i  in  AW  register being claimed by the issued instruction
- flush_i  in  1  clear all busy bits (pipeline flush)
- raddr_i  in  NRD*AW  read addresses; port j at [j*AW +: AW]
- rdata_o  out  NRD*XLEN  read data, combinational
- rbusy_o  out  NRD  busy flag per read port, combinational
- ready_o  out  1  high once the clear sweep is done; reset value 0

## Operation
- State machine, two states:
  - INIT: entered on reset; sweep counter cnt resets to 0; each cycle regs[cnt] <= 0 and cnt++.
  - RUN: entered after the cycle in which cnt == NREGS-1.
- ready_o is 1 only in RUN.
- Busy vector busy[NREGS-1:0] resets asynchronously to all zero.
- The register array has no reset and is only written by the sweep or by write ports.
- In INIT:
  - we_i, set_i and flush_i are ignored.
  - rdata_o = 0 and rbusy_o = 0 on all ports.
- Writes (RUN only):
  - Port k writes when we_i[k] = 1 and its address ≠ 0.
  - Both ports on the same address in the same cycle: port 1 wins.
  - Every accepted write clears busy[waddr].
- Issue (RUN only): set_i with set_addr_i ≠ 0 sets busy[set_addr_i]. set_addr_i = 0 is ignored.
- Simultaneous events on the same address:
  - set and write-back in the same cycle: set wins, busy stays 1 (a new writer claims the register as the old one retires).
  - flush_i: all busy bits become 0 on the next edge and overrides any set in that cycle. Writes still land in the same cycle.
- Read port j, in priority order:
  - addr = 0 → data 0, busy 0;
  - else write port 1 active on addr → wdata port 1, busy 0;
  - else write port 0 active on addr → wdata port 0, busy 0;
  - else → regs[addr], busy[addr].
- A pending set in the same cycle does not affect rbusy_o until the next cycle.
- Reset mid-operation: busy cleared, ready_o drops immediately (asynchronously), and the sweep restarts from 0.

## Timing
- Reads, forwarding and rbusy_o are combinational, with zero latency.
- Writes, set, clear and flush take effect at the next rising clk.
- The sweep lasts exactly NREGS cycles after rst_n deasserts. ready_o rises on edge NREGS; the first accepted write is on edge NREGS+1.
- No handshake: callers must hold we_i/set_i low until ready_o = 1, and anything driven earlier is discarded.

## Test plan
- Reset, then idle → ready_o is 0 for 32 cycles and 1 from edge 32; every read returns 0 and busy 0 throughout.
- After ready: write x5 = 0xDEADBEEF on port 0 → same-cycle read of x5 returns 0xDEADBEEF, and a next-cycle read returns the stored value. A write to x0 → read of x0 stays 0.
- Both ports write x7 (port 0 = 0x11, port 1 = 0x22) → same-cycle forward and stored value are both 0x22.
- set x9, then 3 cycles later port 0 writes x9 = 0x5 → rbusy is 1 for those 3 cycles, drops to 0 combinationally in the write cycle, and stays 0 after.
- set x9 and write x9 in the same cycle → busy[x9] is 1 next cycle. Then flush_i together with set x10 → busy[x9] = busy[x10] = 0.
- rst_n pulsed low mid-run with busy bits set → ready_o drops immediately and all busy bits are 0. Registers read 0 after the new 32-cycle sweep, including previously written ones.
